// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared widths, index type and dump-engine state encoding for lc3_regfile
package lc3_pkg;

    localparam int REG_W    = 16;
    localparam int NUM_REGS = 8;

    typedef logic [2:0] reg_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD,
        DONE
    } dump_state_t;

endpackage

// File: rtl/lc3_regfile_if.sv
// rtl/lc3_regfile_if.sv - register-file access and dump-port bundle; slave side is the register file
interface lc3_regfile_if
    import lc3_pkg::*;
#(
    parameter int WIDTH = REG_W
);

    logic             LD_REG;
    reg_idx_t         DR;
    logic [WIDTH-1:0] Din;
    reg_idx_t         SR1;
    reg_idx_t         SR2;
    logic [WIDTH-1:0] SR1_Out;
    logic [WIDTH-1:0] SR2_Out;
    logic             Dump_Start;
    logic             Dump_Busy;
    logic             Dump_Valid;
    reg_idx_t         Dump_Idx;
    logic [WIDTH-1:0] Dump_Data;
    logic             Dump_Done;

    modport slave (
        input  LD_REG, DR, Din, SR1, SR2, Dump_Start,
        output SR1_Out, SR2_Out, Dump_Busy, Dump_Valid, Dump_Idx, Dump_Data, Dump_Done
    );

    modport master (
        output LD_REG, DR, Din, SR1, SR2, Dump_Start,
        input  SR1_Out, SR2_Out, Dump_Busy, Dump_Valid, Dump_Idx, Dump_Data, Dump_Done
    );

endinterface

// File: rtl/regfile_dump_fsm.sv
// rtl/regfile_dump_fsm.sv - sequences R0..R7 onto the dump port, each held DUMP_HOLD cycles
module regfile_dump_fsm
    import lc3_pkg::*;
#(
    parameter int DUMP_HOLD = 1
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     start,
    output reg_idx_t sel,
    output logic     load,
    output logic     busy,
    output logic     valid,
    output logic     done,
    output reg_idx_t dump_idx
);

    localparam logic [15:0] HOLD_RELOAD = 16'(DUMP_HOLD - 1);

    dump_state_t state_q, state_d;
    reg_idx_t    idx_q, idx_d;
    reg_idx_t    didx_q, didx_d;
    logic [15:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            didx_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            didx_q  <= didx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        didx_d  = didx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end
            LOAD: begin
                didx_d  = idx_q;
                cnt_d   = HOLD_RELOAD;
                state_d = HOLD;
            end
            HOLD: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (idx_q == 3'd7) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = LOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The top captures the snapshot on the edge that leaves LOAD, so writes on that edge are missed.
    assign sel      = idx_q;
    assign load     = (state_q == LOAD);
    assign busy     = (state_q != IDLE);
    assign valid    = (state_q == HOLD);
    assign done     = (state_q == DONE);
    assign dump_idx = didx_q;

endmodule

// File: rtl/lc3_regfile.sv
// rtl/lc3_regfile.sv - 8x16 SLC-3 register file with two async read ports and a registered dump port
// Optional write-through forwarding on the read ports: REGFILE_BYPASS_EN.
module lc3_regfile
    import lc3_pkg::*;
#(
    parameter int WIDTH     = REG_W,
    parameter int DUMP_HOLD = 1
) (
    input  logic          Clk,
    input  logic          Reset,
    lc3_regfile_if.slave  bus
);

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic [WIDTH-1:0] stored1;
    logic [WIDTH-1:0] stored2;
    logic [WIDTH-1:0] dump_data_q;
    reg_idx_t         dump_sel;
    logic             dump_load;
    reg_idx_t         dump_idx;
    logic             dump_busy;
    logic             dump_valid;
    logic             dump_done;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.LD_REG) begin
            regs[bus.DR] <= bus.Din;
        end
    end

    assign stored1 = regs[bus.SR1];
    assign stored2 = regs[bus.SR2];

`ifdef REGFILE_BYPASS_EN
    assign bus.SR1_Out = (bus.LD_REG && (bus.SR1 == bus.DR)) ? bus.Din : stored1;
    assign bus.SR2_Out = (bus.LD_REG && (bus.SR2 == bus.DR)) ? bus.Din : stored2;
`else
    assign bus.SR1_Out = stored1;
    assign bus.SR2_Out = stored2;
`endif

    regfile_dump_fsm #(
        .DUMP_HOLD (DUMP_HOLD)
    ) u_dump_fsm (
        .clk      (Clk),
        .reset    (Reset),
        .start    (bus.Dump_Start),
        .sel      (dump_sel),
        .load     (dump_load),
        .busy     (dump_busy),
        .valid    (dump_valid),
        .done     (dump_done),
        .dump_idx (dump_idx)
    );

    // Snapshot reads the stored array directly so forwarding never leaks into the dump.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            dump_data_q <= '0;
        end else if (dump_load) begin
            dump_data_q <= regs[dump_sel];
        end
    end

    assign bus.Dump_Busy  = dump_busy;
    assign bus.Dump_Valid = dump_valid;
    assign bus.Dump_Idx   = dump_idx;
    assign bus.Dump_Data  = dump_data_q;
    assign bus.Dump_Done  = dump_done;

endmodule
